// File: rtl/fft_tile_stream_buffer.sv
// fft_tile_stream_buffer: captures a job of FFT result entries (one complex
// 4x4 tile per lane) and streams them back as one tile plane per beat,
// either real+imag interleaved per lane or real planes only.
module fft_tile_stream_buffer #(
  parameter  int LANES  = 4,
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 13,
  localparam int OUT_W  = 16 * DATA_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [ADDR_W:0]             ctx_length,
  input  logic                        out_mode,
  input  logic                        in_valid,
  input  logic [LANES*32*DATA_W-1:0]  in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NSL   = 2 * LANES;        // tile planes per entry
  localparam int BW    = $clog2(NSL);

  typedef logic [NSL-1:0][OUT_W-1:0] entry_t;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic            mode_q, mode_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0] rd_addr_q, rd_addr_d;   // entries fetched so far
  logic [BW-1:0]   beat_q, beat_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic            we, fetch;
  logic [BW-1:0]   nb_last, sel;

  entry_t mem [DEPTH];
  entry_t ent_q;                           // synchronous read register

  // Over DEPTH means top bit set with any lower bit set.
  wire len_illegal = ctx_length[ADDR_W] && |ctx_length[ADDR_W-1:0];

  assign nb_last   = mode_q ? BW'(LANES - 1) : BW'(NSL - 1);
  assign sel       = mode_q ? (beat_q << 1) : beat_q;
  assign in_ready  = (state_q == S_FILL);
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? ent_q[sel] : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  // Next-state logic: job control, fill addressing and beat sequencing.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    mode_d      = mode_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    we          = 1'b0;
    fetch       = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        if (ctx_length == '0) state_d = S_DONE;
        else if (len_illegal) err_d = 1'b1;
        else begin
          err_d     = 1'b0;
          len_d     = ctx_length;
          mode_d    = out_mode;
          wr_addr_d = '0;
          rd_addr_d = '0;
          beat_d    = '0;
          state_d   = S_FILL;
        end
      end
      S_FILL: if (in_valid) begin
        we        = 1'b1;
        wr_addr_d = wr_addr_q + ADDR_W'(1);
        if ({1'b0, wr_addr_q} == len_q - (ADDR_W+1)'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!out_valid_q) begin
          // First DRAIN cycle: prefetch entry 0.
          fetch       = 1'b1;
          rd_addr_d   = rd_addr_q + (ADDR_W+1)'(1);
          out_valid_d = 1'b1;
          beat_d      = '0;
        end else if (out_ready) begin
          if (beat_q == nb_last) begin
            beat_d = '0;
            if (rd_addr_q != len_q) begin
              // Fetch next entry during the last beat: no bubble.
              fetch     = 1'b1;
              rd_addr_d = rd_addr_q + (ADDR_W+1)'(1);
            end else begin
              out_valid_d = 1'b0;
              state_d     = S_DONE;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      mode_q      <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Entry storage write port; contents survive reset and new jobs.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr_q] <= in_data;
  end

  // Entry storage read port, one-cycle latency, held while stalled.
  always_ff @(posedge clk) begin
    if (fetch) ent_q <= mem[rd_addr_q[ADDR_W-1:0]];
  end

endmodule

// File: doc/fft_tile_stream_buffer.md
# fft_tile_stream_buffer

Parametrised buffer between a bank of 2-D 4x4 FFT lanes and the cacheline output path of the convolution layer. It captures a job of `ctx_length` FFT result entries, each holding one complex 4x4 tile per lane. It then streams the stored entries back as 16-word cachelines under valid/ready backpressure. Output is either full complex (real and imaginary planes) or real-only.

## Interface
- `LANES`, 4: FFT lanes per entry.
- `DATA_W`, 32: bits per real or imaginary word.
- `ADDR_W`, 13: entry address width; depth is `DEPTH = 2**ADDR_W`.
- `OUT_W` (derived, not overridable): `16*DATA_W`, one tile plane per beat.

- `clk` input 1: single clock; everything is rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle job start; honoured only in IDLE.
- `ctx_length` input ADDR_W+1: entries in the job; sampled on `start`.
- `out_mode` input 1: 0 = real+imag, 1 = real only; sampled on `start`.
- `in_valid` input 1: input entry valid.
- `in_data` input LANES*32*DATA_W: one entry. Word (lane l, plane p, element k) sits at bit offset `((2l+p)*16+k)*DATA_W`. p=0 is real, p=1 is imag, k=4*row+col.
- `in_ready` output 1: entry accepted when `in_valid && in_ready`.
- `out_valid` output 1: `out_data` holds a beat.
- `out_ready` input 1: beat consumed when `out_valid && out_ready`.
- `out_data` output OUT_W: one tile plane, element k at `[k*DATA_W +: DATA_W]`.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse at job end.
- `err` output 1: sticky; set on an illegal `ctx_length`, cleared by the next legal `start`.

## Operation
- States: IDLE, FILL, DRAIN, DONE.
- **IDLE**
  - On `start` with `ctx_length==0`: go to DONE.
  - On `start` with `ctx_length>DEPTH`: set `err`, stay in IDLE.
  - On any other `start`: clear `err`, latch length and mode, clear both address counters, go to FILL.
- **FILL**
  - `in_ready=1`, combinational from state.
  - Each accepted entry is written at `wr_addr`, then `wr_addr` increments.
  - The write of entry `ctx_length-1` moves the state to DRAIN.
- **DRAIN**
  - Memory has a synchronous 1-cycle read.
  - Each entry produces `NB` beats: `NB = 2*LANES` in mode 0, `NB = LANES` in mode 1.
  - Mode 0 beat b is `in_data` slice b, giving the order lane0 re, lane0 im, lane1 re, and so on.
  - Mode 1 beat b is slice 2b.
  - The beat counter wraps at NB and advances `rd_addr`.
  - After the last beat of entry `ctx_length-1` is accepted, go to DONE.
- **DONE**: `done=1` for one cycle, then IDLE.
- Ignored inputs:
  - `start` outside IDLE.
  - `in_valid` outside FILL; `in_ready` is 0 there.
- Memory contents are not cleared by reset or by a new job.

## Timing
- Reset values (asynchronous, immediate on `reset_n` low):
  - `in_ready`, `out_valid`, `busy`, `done`, `err` = 0.
  - `out_data` = 0.
  - State IDLE; all counters 0.
  - Reset mid-job abandons the job; no `done` pulse.
- `start` at cycle t:
  - `busy` is high at t+1.
  - `in_ready` is high at t+1 for a legal non-zero length.
- Zero length: `done` is high at t+1 and `busy` at t+1 only.
- FILL: one entry per cycle at full rate. The last accepted write at cycle w gives DRAIN at w+1. The first `out_valid` is at w+2.
- DRAIN stall: while `out_valid && !out_ready`, `out_data` and `out_valid` stay stable and no counter advances.
- DRAIN throughput:
  - With `out_ready` held high, one beat per cycle.
  - No bubble between entries; the next entry is prefetched during the last beat.
  - Total drain from first `out_valid` to last handshake is `ctx_length*NB` cycles.
- Job end: last handshake at cycle d gives `done` at d+1. `out_valid` is 0 at d+1. `busy` is 0 at d+2.
- Boundaries:
  - `ctx_length==DEPTH` is legal; `wr_addr` wraps to 0 and is not reused.
  - `ctx_length==1` is legal.
  - `start` in the same cycle as `done` is ignored.

## Test plan
- **Nominal mode 0**
  - Stimulus: LANES=4, `ctx_length=3`; word value = `{entry,lane,plane,k}` encoded; `out_ready=1`.
  - Required: 24 consecutive beats in lane/plane order; `done` 1 cycle after the 24th.
- **Mode 1**
  - Stimulus: same data, `out_mode=1`.
  - Required: 12 beats, real planes only, lane order 0..3 per entry.
- **Backpressure**
  - Stimulus: `ctx_length=5`, mode 0, `out_ready` random at 30% duty.
  - Required: exactly 40 beats, none lost or duplicated; `out_data` stable on every stalled cycle.
- **Length edges**
  - `ctx_length=0`: `done` at t+1, no `out_valid`.
  - `ctx_length=8193` (ADDR_W=13): `err=1`, `busy` stays 0.
  - A following legal `start`: `err` clears.
- **Async reset mid-DRAIN**
  - Stimulus: drop `reset_n` between clock edges.
  - Required: `out_valid`, `busy` and `out_data` go to 0 immediately, with no `done`; after release, a new `ctx_length=2` job completes correctly.
- **Ignored inputs**
  - `in_valid` pulses in IDLE and DRAIN: no write, beat count unchanged.
  - `start` during FILL: no restart, `ctx_length` unchanged.
